// File: rtl/fetch_unit.sv
// fetch_unit: byte-serial instruction fetch and decode for a Y86-64 style ISA.
// One instruction is fetched per accepted pc_valid, one byte per memory ack,
// then reported with a one-cycle instr_valid pulse.
//
// Optional build macro: FETCH_TIMEOUT_EN adds a 16-cycle ack watchdog in FETCH
// that aborts the fetch with imem_error=1. Without it FETCH waits forever.
//
// Handshake: in FETCH, imem_req is high and imem_addr = base + byte count; both
// hold stable until a rising edge samples imem_ack=1, which consumes imem_data
// (and imem_err) for that address. imem_ack is ignored in every other state and
// pc_valid is only accepted in IDLE.
//
// State is observable from the outputs: imem_req=1 only in FETCH,
// instr_valid=1 only in DONE, busy=0 only in IDLE.
module fetch_unit #(
  parameter int n = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] PC,
  input  logic         pc_valid,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic [7:0]   imem_data,
  input  logic         imem_ack,
  input  logic         imem_err,
  output logic [3:0]   icode,
  output logic [3:0]   ifun,
  output logic [3:0]   rA,
  output logic [3:0]   rB,
  output logic [n-1:0] valC,
  output logic [n-1:0] valP,
  output logic         instr_valid,
  output logic         instr_invalid,
  output logic         imem_error,
  output logic         halt,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] base_q;
  logic [3:0]   cnt_q;
  logic [3:0]   len_q;
  logic [3:0]   cur_len;
  logic [3:0]   cur_icode;
  logic         last_byte;
  logic         take;
  logic         valc_en;
  logic [3:0]   valc_idx;

  // Instruction length in bytes from the opcode nibble; undefined opcodes
  // are treated as one-byte instructions.
  function automatic logic [3:0] decode_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       decode_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: decode_len = 4'd2;
      4'h7, 4'h8:             decode_len = 4'd9;
      4'h3, 4'h4, 4'h5:       decode_len = 4'd10;
      default:                decode_len = 4'd1;
    endcase
  endfunction

  // A byte is consumed only while fetching.
  assign take = (state_q == FETCH) && imem_ack;

  assign imem_req    = (state_q == FETCH);
  assign busy        = (state_q != IDLE);
  assign instr_valid = (state_q == DONE);
  assign imem_addr   = (state_q == FETCH) ? (base_q + {{(n-4){1'b0}}, cnt_q}) : '0;

  // Per-byte decode: the opcode byte is decoded straight off the bus, later
  // bytes use the opcode and length already captured.
  always_comb begin
    cur_icode = (cnt_q == 4'd0) ? imem_data[7:4] : icode;
    cur_len   = (cnt_q == 4'd0) ? decode_len(imem_data[7:4]) : len_q;
    last_byte = ((cnt_q + 4'd1) == cur_len);
    valc_en   = 1'b0;
    valc_idx  = 4'd0;
    if ((icode inside {4'h3, 4'h4, 4'h5}) && (cnt_q >= 4'd2)) begin
      valc_en  = 1'b1;
      valc_idx = cnt_q - 4'd2;
    end else if ((icode inside {4'h7, 4'h8}) && (cnt_q >= 4'd1)) begin
      valc_en  = 1'b1;
      valc_idx = cnt_q - 4'd1;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wd_q;
  logic       wd_expire;

  // 16th consecutive FETCH cycle without an ack ends the fetch.
  assign wd_expire = (state_q == FETCH) && !imem_ack && (wd_q == 4'hF);

  // Watchdog counts FETCH cycles since entry or the last ack.
  always_ff @(posedge clk) begin
    if (reset || (state_q != FETCH) || imem_ack) begin
      wd_q <= 4'd0;
    end else begin
      wd_q <= wd_q + 4'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pc_valid) state_d = FETCH;
      end
      FETCH: begin
        if (take && (imem_err || last_byte)) begin
          state_d = DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wd_expire) begin
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fetch datapath: latch the start address, capture fields as bytes arrive,
  // and finalise valP/halt on the last byte. Outputs hold in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q        <= '0;
      cnt_q         <= 4'd0;
      len_q         <= 4'd0;
      icode         <= 4'h0;
      ifun          <= 4'h0;
      rA            <= 4'hF;
      rB            <= 4'hF;
      valC          <= '0;
      valP          <= '0;
      instr_invalid <= 1'b0;
      imem_error    <= 1'b0;
      halt          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_valid) begin
            base_q        <= PC;
            cnt_q         <= 4'd0;
            len_q         <= 4'd0;
            icode         <= 4'h0;
            ifun          <= 4'h0;
            rA            <= 4'hF;
            rB            <= 4'hF;
            valC          <= '0;
            valP          <= '0;
            instr_invalid <= 1'b0;
            imem_error    <= 1'b0;
            halt          <= 1'b0;
          end
        end
        FETCH: begin
          if (take) begin
            cnt_q <= cnt_q + 4'd1;
            if (imem_err) begin
              imem_error <= 1'b1;
            end else begin
              if (cnt_q == 4'd0) begin
                icode         <= imem_data[7:4];
                ifun          <= imem_data[3:0];
                len_q         <= cur_len;
                instr_invalid <= (imem_data[7:4] >= 4'hC);
              end
              if ((cnt_q == 4'd1) && (len_q >= 4'd2) && !(icode inside {4'h7, 4'h8})) begin
                rA <= imem_data[7:4];
                rB <= imem_data[3:0];
              end
              for (int k = 0; k < 8; k++) begin
                if (valc_en && (valc_idx == 4'(k))) begin
                  valC[k*8 +: 8] <= imem_data;
                end
              end
              if (last_byte) begin
                valP <= base_q + {{(n-4){1'b0}}, cur_len};
                halt <= (cur_icode == 4'h0);
              end
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wd_expire) begin
            imem_error <= 1'b1;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, randomized instructions against a
// byte-table reference model, and hand-written reset/abort/intrusion sequences.
// Latency convention: counting the pc_valid cycle as cycle 1, instr_valid is
// high in cycle L+2, i.e. L rising edges after the edge that accepts pc_valid.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] PC;
  logic        pc_valid;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [7:0]  imem_data;
  logic        imem_ack;
  logic        imem_err;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        instr_valid, instr_invalid, imem_error, halt, busy;

  fetch_unit #(.n(64)) dut (
    .clk(clk), .reset(reset), .PC(PC), .pc_valid(pc_valid),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_ack(imem_ack), .imem_err(imem_err),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .instr_invalid(instr_invalid),
    .imem_error(imem_error), .halt(halt), .busy(busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        inv, hlt;
    logic [3:0]  len;
  } exp_t;

  typedef struct {
    logic [63:0]     pc;
    logic [9:0][7:0] b;
    int              wmax;
    exp_t            e;
  } vec_t;

  vec_t vecs[$];

  // ---------------- memory responder ----------------
  logic [7:0]  mem_b [10];
  logic [63:0] cur_base;
  logic [63:0] addr_log[$];
  int          wait_max = 0;
  int          stall_left = 0;
  int          err_at = -1;
  bit          mute = 0;

  always @(negedge clk) begin
    logic [63:0] idx;
    imem_ack  = 1'b0;
    imem_err  = 1'b0;
    imem_data = 8'h00;
    if (imem_req && !mute) begin
      if (stall_left > 0) begin
        stall_left = stall_left - 1;
      end else begin
        idx       = imem_addr - cur_base;
        imem_ack  = 1'b1;
        imem_data = (idx < 64'd10) ? mem_b[idx[3:0]] : 8'h00;
        imem_err  = (err_at >= 0) && (idx == 64'(err_at));
        addr_log.push_back(imem_addr);
        stall_left = (wait_max > 0) ? int'($urandom_range(wait_max, 0)) : 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0][7:0] mb(input logic [7:0] a0, a1, a2, a3, a4,
                                         input logic [7:0] a5, a6, a7, a8, a9);
    logic [9:0][7:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4;
    r[5] = a5; r[6] = a6; r[7] = a7; r[8] = a8; r[9] = a9;
    return r;
  endfunction

  task automatic add_vec(input logic [63:0] pc, input logic [9:0][7:0] b, input int wmax,
                         input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc, vp,
                         input logic inv, hlt, input logic [3:0] len);
    vec_t v;
    v.pc = pc; v.b = b; v.wmax = wmax;
    v.e.icode = ic; v.e.ifun = fn; v.e.ra = ra; v.e.rb = rb;
    v.e.valc = vc; v.e.valp = vp; v.e.inv = inv; v.e.hlt = hlt; v.e.len = len;
    vecs.push_back(v);
  endtask

  // Reference model: whole-instruction view of the byte image in mem_b.
  function automatic exp_t model(input logic [63:0] pc);
    int   len_tab[16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    exp_t e;
    logic [3:0] ic;
    ic      = mem_b[0][7:4];
    e.icode = ic;
    e.ifun  = mem_b[0][3:0];
    e.len   = 4'(len_tab[ic]);
    e.ra    = 4'hF;
    e.rb    = 4'hF;
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
      e.ra = mem_b[1][7:4];
      e.rb = mem_b[1][3:0];
    end
    e.valc = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (ic inside {4'h3, 4'h4, 4'h5}) e.valc[i*8 +: 8] = mem_b[2+i];
      else if (ic inside {4'h7, 4'h8}) e.valc[i*8 +: 8] = mem_b[1+i];
    end
    e.valp = pc + 64'(len_tab[ic]);
    e.inv  = (ic >= 4'hC);
    e.hlt  = (ic == 4'h0);
    return e;
  endfunction

  // Issue one pc_valid and wait (bounded) for instr_valid; optionally
  // re-assert pc_valid mid-fetch at lat==intr_at.
  task automatic run_instr(input logic [63:0] pc, input int wmax, input int eidx,
                           input int intr_at, input string tag, output int lat);
    bit seen;
    cur_base = pc;
    wait_max = wmax;
    err_at   = eidx;
    addr_log.delete();
    stall_left = (wmax > 0) ? int'($urandom_range(wmax, 0)) : 0;
    @(posedge clk); #1;
    PC = pc;
    pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    PC = 64'd0;
    lat = 0;
    seen = 0;
    while (!seen && lat < 200) begin
      if (instr_valid) begin
        seen = 1;
      end else begin
        if (lat == intr_at) begin
          pc_valid = 1'b1;
          PC = 64'h900;
        end else begin
          pc_valid = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    pc_valid = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(posedge clk); #1;
    check({tag, "_pulse_low"}, 64'(instr_valid), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  task automatic check_fields(input string tag, input exp_t e);
    check({tag, "_icode"}, 64'(icode), 64'(e.icode));
    check({tag, "_ifun"}, 64'(ifun), 64'(e.ifun));
    check({tag, "_rA"}, 64'(rA), 64'(e.ra));
    check({tag, "_rB"}, 64'(rB), 64'(e.rb));
    check({tag, "_valC"}, valC, e.valc);
    check({tag, "_valP"}, valP, e.valp);
    check({tag, "_invalid"}, 64'(instr_invalid), 64'(e.inv));
    check({tag, "_halt"}, 64'(halt), 64'(e.hlt));
    check({tag, "_imem_error"}, 64'(imem_error), 64'd0);
  endtask

  task automatic check_addrs(input string tag, input logic [63:0] pc, input int len);
    check({tag, "_nbytes"}, 64'(addr_log.size()), 64'(len));
    for (int j = 0; j < len && j < addr_log.size(); j++) begin
      check($sformatf("%s_addr%0d", tag, j), addr_log[j], pc + 64'(j));
    end
  endtask

  task automatic load_bytes(input logic [9:0][7:0] b);
    for (int j = 0; j < 10; j++) mem_b[j] = b[j];
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time bound");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time bound exceeded");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   lat;
    int   cnt;
    int   hits;
    exp_t e;
    string tag;

    reset = 1'b1; pc_valid = 1'b1; PC = 64'hDEAD;
    imem_ack = 1'b0; imem_err = 1'b0; imem_data = 8'h00;
    cur_base = 64'd0;
    for (int j = 0; j < 10; j++) mem_b[j] = 8'h00;

    // Reset held with pc_valid high: reset must win.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_icode", 64'(icode), 64'd0);
    check("rst_ifun", 64'(ifun), 64'd0);
    check("rst_rA", 64'(rA), 64'hF);
    check("rst_rB", 64'(rB), 64'hF);
    check("rst_valC", valC, 64'd0);
    check("rst_valP", valP, 64'd0);
    check("rst_flags", {61'd0, instr_invalid, imem_error, halt}, 64'd0);
    reset = 1'b0; pc_valid = 1'b0;

    // Directed vector table.
    add_vec(64'h0, mb(8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0,
            4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 0, 0, 4'd1);
    add_vec(64'h100, mb(8'h30, 8'hF3, 8'h08, 0, 0, 0, 0, 0, 0, 0), 0,
            4'h3, 4'h0, 4'hF, 4'h3, 64'h8, 64'h10A, 0, 0, 4'd10);
    add_vec(64'h20, mb(8'h70, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0), 0,
            4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h29, 0, 0, 4'd9);
    add_vec(64'h40, mb(8'hC0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0,
            4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 1, 0, 4'd1);
    add_vec(64'h50, mb(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0,
            4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 0, 1, 4'd1);
    add_vec(64'hFFFF_FFFF_FFFF_FFFF,
            mb(8'h30, 8'hF2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88), 0,
            4'h3, 4'h0, 4'hF, 4'h2, 64'h8877_6655_4433_2211, 64'h9, 0, 0, 4'd10);
    add_vec(64'h200, mb(8'h60, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0), 0,
            4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h202, 0, 0, 4'd2);
    add_vec(64'h300,
            mb(8'h80, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00), 0,
            4'h8, 4'h0, 4'hF, 4'hF, 64'h0123_4567_89AB_CDEF, 64'h309, 0, 0, 4'd9);
    add_vec(64'h10, mb(8'h21, 8'h34, 0, 0, 0, 0, 0, 0, 0, 0), 3,
            4'h2, 4'h1, 4'h3, 4'h4, 64'h0, 64'h12, 0, 0, 4'd2);
    add_vec(64'h1000, mb(8'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0,
            4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1001, 0, 0, 4'd1);
    add_vec(64'h80,
            mb(8'h50, 8'h67, 8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12), 1,
            4'h5, 4'h0, 4'h6, 4'h7, 64'h1234_5678_9ABC_DEF0, 64'h8A, 0, 0, 4'd10);

    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      load_bytes(vecs[i].b);
      run_instr(vecs[i].pc, vecs[i].wmax, -1, -1, tag, lat);
      if (vecs[i].wmax == 0) check({tag, "_latency"}, 64'(lat), 64'(vecs[i].e.len));
      check_fields(tag, vecs[i].e);
      check_addrs(tag, vecs[i].pc, int'(vecs[i].e.len));
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_hold_icode"}, 64'(icode), 64'(vecs[i].e.icode));
      check({tag, "_hold_valP"}, valP, vecs[i].e.valp);
    end

    // Randomized instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [63:0] pc;
      tag = $sformatf("rnd%0d", i);
      for (int j = 0; j < 10; j++) mem_b[j] = 8'($urandom_range(255, 0));
      pc = (i % 5 == 0) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(7, 0)))
                        : {$urandom, $urandom};
      e = model(pc);
      run_instr(pc, int'($urandom_range(3, 0)), -1, -1, tag, lat);
      check_fields(tag, e);
      check_addrs(tag, pc, int'(e.len));
    end

    // Reset after the 3rd ack of an irmovq: fetch discarded.
    load_bytes(mb(8'h30, 8'hF3, 8'h08, 0, 0, 0, 0, 0, 0, 0));
    cur_base = 64'h400; wait_max = 0; err_at = -1; stall_left = 0;
    addr_log.delete();
    @(posedge clk); #1;
    PC = 64'h400; pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    cnt = 0;
    while (addr_log.size() < 3 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("midrst_reached_3rd_ack", 64'(addr_log.size() >= 3), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_req", 64'(imem_req), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(instr_valid), 64'd0);
    check("midrst_icode", 64'(icode), 64'd0);
    check("midrst_rB", 64'(rB), 64'hF);
    check("midrst_valC", valC, 64'd0);
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (instr_valid || busy) hits++;
    end
    check("midrst_stays_idle", 64'(hits), 64'd0);

    // Second pc_valid during FETCH is ignored.
    e = model(64'h500);
    run_instr(64'h500, 2, -1, 2, "intr", lat);
    check_fields("intr", e);
    check_addrs("intr", 64'h500, 10);

    // Memory fault on byte 2 of an irmovq: fields so far are kept.
    load_bytes(mb(8'h30, 8'hF3, 8'h08, 0, 0, 0, 0, 0, 0, 0));
    run_instr(64'h600, 0, 2, -1, "err2", lat);
    check("err2_imem_error", 64'(imem_error), 64'd1);
    check("err2_icode", 64'(icode), 64'h3);
    check("err2_rA", 64'(rA), 64'hF);
    check("err2_rB", 64'(rB), 64'h3);
    check("err2_valC", valC, 64'd0);
    check("err2_halt", 64'(halt), 64'd0);
    check("err2_latency", 64'(lat), 64'd3);

    // Fault on the opcode byte.
    load_bytes(mb(8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(64'h700, 0, 0, -1, "err0", lat);
    check("err0_imem_error", 64'(imem_error), 64'd1);
    check("err0_icode", 64'(icode), 64'h0);
    check("err0_halt", 64'(halt), 64'd0);

    // Next accepted fetch clears the error flag.
    err_at = -1;
    e = model(64'h710);
    run_instr(64'h710, 0, -1, -1, "after_err", lat);
    check_fields("after_err", e);

`ifdef FETCH_TIMEOUT_EN
    // No ack at all: watchdog aborts after 16 FETCH cycles.
    mute = 1;
    run_instr(64'h800, 0, -1, -1, "wdog", lat);
    mute = 0;
    check("wdog_imem_error", 64'(imem_error), 64'd1);
    check("wdog_latency", 64'(lat), 64'd16);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter n, default 64, meaning the address/data word width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, one clock (clk), sampled on rising edge.
REQ-004 SHALL have port PC  input  n  fetch address, the output of the PC-update stage.
REQ-005 SHALL have port pc_valid  input  1  start strobe; PC is valid.
REQ-006 SHALL have port imem_req  output  1  byte read request.
REQ-007 SHALL have port imem_addr  output  n  byte address.
REQ-008 SHALL have port imem_data  input  8  read byte, valid with ack.
REQ-009 SHALL have port imem_ack  input  1  read completed.
REQ-010 SHALL have port imem_err  input  1  address fault, valid with ack.
REQ-011 SHALL have ports icode, ifun, rA, rB  output  4 each  decoded fields.
REQ-012 SHALL have ports valC, valP  output  n each  constant word; next sequential PC.
REQ-013 SHALL have port instr_valid  output  1  one-cycle done pulse.
REQ-014 SHALL have ports instr_invalid, imem_error, halt, busy  output  1 each  status flags.

Function
REQ-015 SHALL use FSM states IDLE, FETCH, DONE.
REQ-016 IDLE + pc_valid=1 SHALL latch PC into base, clear byte counter cnt, clear all outputs except busy, and enter FETCH next cycle.
REQ-017 FETCH SHALL drive imem_req=1 and imem_addr=base+cnt (mod 2^n, wraps), and hold both stable until ack.
REQ-018 Ack with cnt=0 SHALL load icode=imem_data[7:4], ifun=imem_data[3:0], and set length L: 0,1,9 ->1; 2,6,A,B ->2; 7,8 ->9; 3,4,5 ->10; C-F ->1 with instr_invalid=1.
REQ-019 Ack with cnt=1 and L>=2, icode not 7/8, SHALL load rA=[7:4], rB=[3:0].
REQ-020 valC SHALL be assembled little-endian: bytes 2..9 for icode 3/4/5, bytes 1..8 for icode 7/8; otherwise valC=0.
REQ-021 rA, rB SHALL read 0xF for instructions without a register byte.
REQ-022 Each ack SHALL increment cnt; when cnt+1==L, FSM SHALL enter DONE.
REQ-023 DONE SHALL assert instr_valid for exactly one cycle with valP=base+L (mod 2^n), then return to IDLE.
REQ-024 halt SHALL equal 1 when a completed instruction has icode=0.
REQ-025 Ack with imem_err=1 SHALL abort to DONE with imem_error=1, leaving fields captured so far.
REQ-026 pc_valid SHALL be ignored outside IDLE.
REQ-027 imem_ack SHALL be ignored outside FETCH.
REQ-028 busy SHALL be 1 in FETCH and DONE.
REQ-029 Outputs SHALL hold their values after DONE until the next accepted pc_valid.
REQ-030 Minimum latency SHALL be L+2 cycles from pc_valid to instr_valid with zero-wait acks.

Reset
REQ-031 reset=1 SHALL force IDLE, cnt=0, and imem_req=0, instr_valid=0, busy=0, all flags 0, icode=ifun=0, rA=rB=0xF, valC=valP=imem_addr=0, from the next edge.
REQ-032 reset SHALL take priority over pc_valid and imem_ack, including mid-fetch; the partial fetch SHALL be discarded.

Configuration
REQ-033 With FETCH_TIMEOUT_EN defined, a 4-bit watchdog SHALL count FETCH cycles without ack, clear on each ack, and abort as REQ-025 (imem_error=1) when 16 cycles elapse.
REQ-034 Without FETCH_TIMEOUT_EN, no watchdog logic SHALL exist and FETCH SHALL wait indefinitely.

Verification
REQ-035 PC=0, byte 0x10 -> instr_valid at cycle 3: icode=1, valP=1, valC=0, rA=rB=F.
REQ-036 PC=0x100, bytes 30 F3 08 00 00 00 00 00 00 00 -> icode=3, rA=F, rB=3, valC=8, valP=0x10A, addresses 0x100..0x109.
REQ-037 PC=0x20, bytes 70 40 00 00 00 00 00 00 00 -> icode=7, ifun=0, valC=0x40, valP=0x29.
REQ-038 byte 0xC0 -> instr_invalid=1, valP=PC+1; byte 0x00 -> halt=1.
REQ-039 reset pulsed after 3rd ack of irmovq -> next cycle imem_req=0, busy=0, and no instr_valid; a second pc_valid during FETCH -> ignored.
REQ-040 PC=2^64-1, irmovq -> addresses wrap to 0..8, valP=9; FETCH_TIMEOUT_EN with no ack -> imem_error=1 after 16 cycles.
